// File: rtl/stopwatch_ctrl.sv
// Run control for the warm-up stopwatch: decodes button pulses, divides the system
// clock down to a one-per-second counter enable, and freezes a lap time on the display.
module stopwatch_ctrl #(
    parameter int DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lc,
    input  logic [7:0]  sec_bcd,
    input  logic [7:0]  min_bcd,
    input  logic        sec_co,
    output logic        sec_en,
    output logic        min_en,
    output logic        cnt_clr,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_hold
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   lap_reg;
    logic          active;

    assign active = (state == RUN) || (state == LAP);
    assign sec_en = active && (presc == PMAX);
    assign min_en = sec_en && sec_co;
    assign disp   = (state == LAP) ? lap_reg : {min_bcd, sec_bcd};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            presc    <= '0;
            lap_reg  <= '0;
            cnt_clr  <= 1'b1;
            running  <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            // presc holds outside RUN/LAP so a resumed run finishes the interrupted second
            if (active)
                presc <= (presc == PMAX) ? '0 : presc + 1'b1;

            if (btn_ss) begin
                // start/stop wins over a coincident lap/clear, which is dropped
                case (state)
                    IDLE, PAUSE: begin
                        state    <= RUN;
                        running  <= 1'b1;
                        lap_hold <= 1'b0;
                    end
                    RUN, LAP: begin
                        state    <= PAUSE;
                        running  <= 1'b0;
                        lap_hold <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (btn_lc) begin
                case (state)
                    IDLE, PAUSE: begin
                        state    <= IDLE;
                        running  <= 1'b0;
                        lap_hold <= 1'b0;
                        presc    <= '0;
                        cnt_clr  <= 1'b1;
                    end
                    RUN: begin
                        state    <= LAP;
                        lap_hold <= 1'b1;
                        lap_reg  <= {min_bcd, sec_bcd};
                    end
                    LAP: begin
                        state    <= RUN;
                        lap_hold <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV = 4: BCD counters close the loop, and an
// integer-seconds model predicts every output after each clock edge.
module tb_stopwatch_ctrl;
    localparam int DIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

    logic        clk = 1'b0;
    logic        rst, btn_ss, btn_lc, sec_co;
    logic [7:0]  sec_bcd, min_bcd;
    logic        sec_en, min_en, cnt_clr, running, lap_hold;
    logic [15:0] disp;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: total seconds, phase within the second, run mode
    int m_mode  = M_IDLE;
    int m_phase = 0;
    int m_secs  = 0;
    int m_lap   = 0;
    bit m_clr   = 1'b0;

    stopwatch_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lc(btn_lc),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .sec_co(sec_co),
        .sec_en(sec_en), .min_en(min_en), .cnt_clr(cnt_clr),
        .disp(disp), .running(running), .lap_hold(lap_hold)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h59)       return 8'h00;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (cnt_clr)     sec_bcd <= 8'h00;
        else if (sec_en) sec_bcd <= bcd_inc(sec_bcd);
        if (cnt_clr)     min_bcd <= 8'h00;
        else if (min_en) min_bcd <= bcd_inc(min_bcd);
    end
    assign sec_co = (sec_bcd == 8'h59);

    function automatic logic [15:0] to_disp(input int s);
        int mm, ss;
        mm = (s / 60) % 60;
        ss = s % 60;
        return 16'(((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
    endfunction

    function automatic bit m_active();
        return (m_mode == M_RUN) || (m_mode == M_LAP);
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit ss, input bit lc, input bit r);
        int old;
        bit tick;
        old  = m_secs;
        tick = m_active() && (m_phase == DIV - 1);
        if (m_clr)     m_secs = 0;
        else if (tick) m_secs = (m_secs + 1) % 3600;
        m_clr = 1'b0;
        if (!r) begin
            m_mode = M_IDLE; m_phase = 0; m_lap = 0; m_clr = 1'b1;
        end else begin
            if (m_active()) m_phase = (m_phase + 1) % DIV;
            if (ss) begin
                m_mode = (m_mode == M_IDLE || m_mode == M_PAUSE) ? M_RUN : M_PAUSE;
            end else if (lc) begin
                if (m_mode == M_RUN) begin
                    m_mode = M_LAP; m_lap = old;
                end else if (m_mode == M_LAP) begin
                    m_mode = M_RUN;
                end else begin
                    m_mode = M_IDLE; m_clr = 1'b1; m_phase = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        bit       e_sec;
        bit [0:0] b;
        e_sec = m_active() && (m_phase == DIV - 1);
        b = e_sec;                                 chk("sec_en", 16'(sec_en), 16'(b));
        b = e_sec && (m_secs % 60 == 59);          chk("min_en", 16'(min_en), 16'(b));
        b = m_clr;                                 chk("cnt_clr", 16'(cnt_clr), 16'(b));
        b = m_active();                            chk("running", 16'(running), 16'(b));
        b = (m_mode == M_LAP);                     chk("lap_hold", 16'(lap_hold), 16'(b));
        chk("disp", disp, (m_mode == M_LAP) ? to_disp(m_lap) : to_disp(m_secs));
    endtask

    task automatic step(input bit ss, input bit lc, input bit r, input bit do_chk);
        btn_ss = ss; btn_lc = lc; rst = r;
        @(posedge clk);
        model_edge(ss, lc, r);
        #1;
        btn_ss = 1'b0; btn_lc = 1'b0; rst = 1'b1;
        if (do_chk) check_all();
    endtask

    task automatic run_until_secs(input int target, input int budget);
        int n;
        n = 0;
        while (m_secs != target && n < budget) begin
            step(0, 0, 1, 1);
            n++;
        end
        chk("reach_secs", 16'(m_secs), 16'(target));
    endtask

    initial begin
        btn_ss = 1'b0; btn_lc = 1'b0; rst = 1'b0;
        #2;
        // reset held three edges; counters only become defined after the first
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_disp", disp, 16'h0000);
        chk("rst_clr", 16'(cnt_clr), 16'h0001);
        step(0, 0, 1, 1);
        chk("rel_clr", 16'(cnt_clr), 16'h0000);
        step(0, 0, 1, 1);

        // start and run across a minute boundary
        step(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        chk("first_sec_en", 16'(sec_en), 16'h0001);
        step(0, 0, 1, 1);
        chk("first_inc", disp, 16'h0001);
        run_until_secs(60, 400);
        chk("minute_wrap", disp, 16'h0100);
        step(0, 0, 1, 1);

        // pause mid-second, hold 10 cycles, resume
        for (int n = 0; n < 8 && m_phase != 2; n++) step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

        // clear from PAUSE at 03:05, then clear again from IDLE
        run_until_secs(185, 1000);
        step(1, 0, 1, 1);
        chk("pause_305", disp, 16'h0305);
        step(0, 1, 1, 1);
        chk("clr_pulse", 16'(cnt_clr), 16'h0001);
        step(0, 0, 1, 1);
        chk("clr_disp", disp, 16'h0000);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);

        // lap freeze at 00:12, run five more seconds, release
        step(1, 0, 1, 1);
        run_until_secs(12, 100);
        step(0, 1, 1, 1);
        for (int i = 0; i < 5 * DIV; i++) step(0, 0, 1, 1);
        chk("lap_frozen", disp, 16'h0012);
        chk("lap_hold", 16'(lap_hold), 16'h0001);
        step(0, 1, 1, 1);
        chk("lap_release", 16'(lap_hold), 16'h0000);

        // simultaneous buttons in RUN: pause, no capture
        step(1, 1, 1, 1);
        chk("simul_run", 16'(running), 16'h0000);
        step(1, 0, 1, 1);
        step(0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        // reset while in LAP
        step(0, 0, 0, 1);
        chk("rst_in_lap", 16'(lap_hold), 16'h0000);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);

        // randomized button traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0,
                 $urandom_range(0, 399) != 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
